multi_divider: RTL and testbench

Parametrised, multi-channel clock-enable generator, the next generation of the fixed 500 Hz divider.
- Each of NUM_CH channels counts system clock edges against its own runtime-programmable divisor.
- Each channel drives either a one-cycle tick (pulse mode) or a 50% duty square wave (square mode).
- Feeds display scanning, debouncers and slow-rate FSMs across the design.
- All outputs are registered in the clk domain.

---
 rtl/multi_divider_pkg.sv | 23 ++
 rtl/multi_divider_if.sv | 32 +++
 rtl/multi_divider_channel.sv | 95 +++++++++
 rtl/multi_divider.sv | 52 +++++
 tb/tb_multi_divider.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_divider_pkg.sv
// multi_divider_pkg
//   Shared constants and types for the multi-channel clock-enable generator.
//   - mode_e      : channel output mode (pulse tick or 50% square wave)
//   - DIV_MIN     : smallest divisor a channel will accept; smaller writes are clamped
//   - CNT_W_DEF / DEFAULT_DIV_DEF : default counter width and reset divisor
//   - sel_width() : width of a channel-select field for a given channel count
package multi_divider_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int DIV_MIN         = 2;
  localparam int CNT_W_DEF       = 21;
  localparam int DEFAULT_DIV_DEF = 200000;

  // A single channel still needs a 1-bit select so the port never collapses.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_divider_if.sv
// multi_divider_if
//   Control/status bundle of the multi-channel divider.
//   en, mode   : per-channel count enable and output mode
//   div_wr     : one-cycle divisor write strobe, addressed by div_sel, data div_data
//   sync_clr   : phase-aligns every channel (counters and outputs cleared)
//   out        : per-channel tick / square output
//   master drives the controls, slave is the divider itself.
interface multi_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 21,
  parameter int SEL_W  = 2
) ();

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic              sync_clr;
  logic [NUM_CH-1:0] out;

  modport master (
    output en, mode, div_wr, div_sel, div_data, sync_clr,
    input  out
  );

  modport slave (
    input  en, mode, div_wr, div_sel, div_data, sync_clr,
    output out
  );

endinterface

// File: rtl/multi_divider_channel.sv
// divider_channel
//   One divider channel: counter, programmable divisor, registered mode and output.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : count enable
//   mode       : requested mode (0 pulse, 1 square)
//   wr         : decoded divisor write for this channel
//   wr_data    : new divisor (0/1 clamped to DIV_MIN)
//   clr        : synchronous phase clear, keeps divisor and mode
//   out        : registered tick or square output
module divider_channel
  import multi_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             clr,
  output logic             out
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  mode_e            mode_q_reg, mode_q_next;
  logic             out_reg, out_next;

  logic [CNT_W-1:0] wr_div;
  logic             terminal;

  // A divisor below 2 would make div-1 equal 0 or wrap; clamp instead.
  assign wr_div = (wr_data < DIV_MIN_W) ? DIV_MIN_W : wr_data;

  // div >= 2 always, so div-1 in CNT_W bits never underflows and cnt
  // tops out at div-1, never wrapping past the divisor.
  assign terminal = en && (cnt_reg == (div_reg - ONE_W));

  always_comb begin
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    mode_q_next = mode_q_reg;
    out_next    = out_reg;

    if (clr) begin
      cnt_next = '0;
      out_next = 1'b0;
    end else if (wr) begin
      // A write colliding with a terminal event wins: no tick, no toggle.
      div_next = wr_div;
      cnt_next = '0;
      out_next = 1'b0;
    end else if (mode_e'(mode) != mode_q_reg) begin
      // Mode switch restarts the channel from a known phase.
      mode_q_next = mode_e'(mode);
      cnt_next    = '0;
      out_next    = 1'b0;
    end else if (en) begin
      cnt_next = terminal ? '0 : (cnt_reg + ONE_W);
      if (mode_q_reg == MODE_PULSE) begin
        out_next = terminal;
      end else begin
        out_next = terminal ? ~out_reg : out_reg;
      end
    end else begin
      // Disabled: a pulse output drops, a square output freezes.
      if (mode_q_reg == MODE_PULSE) begin
        out_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      div_reg    <= DEF_DIV_W;
      mode_q_reg <= MODE_PULSE;
      out_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      mode_q_reg <= mode_q_next;
      out_reg    <= out_next;
    end
  end

  assign out = out_reg;

endmodule

// File: rtl/multi_divider.sv
// multi_divider
//   Multi-channel clock-enable generator. Each channel divides clk by its own
//   runtime-programmable divisor and emits either a one-cycle tick or a 50%
//   square wave.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset (divisors revert to DEFAULT_DIV)
//   bus   : multi_divider_if slave (en, mode, div_wr/div_sel/div_data,
//           sync_clr in; out registered out)
module multi_divider
  import multi_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int SEL_W       = sel_width(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  multi_divider_if.slave   bus
);

  logic [NUM_CH-1:0] wr_strobe;
  logic [NUM_CH-1:0] ch_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_ADDR = SEL_W'(gi);

      // Only addresses 0..NUM_CH-1 have a matching channel, so a select
      // beyond the last channel reaches nobody and the write is dropped.
      assign wr_strobe[gi] = bus.div_wr && (bus.div_sel == CH_ADDR);

      divider_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en[gi]),
        .mode    (bus.mode[gi]),
        .wr      (wr_strobe[gi]),
        .wr_data (bus.div_data),
        .clr     (bus.sync_clr),
        .out     (ch_out[gi])
      );
    end
  endgenerate

  assign bus.out = ch_out;

endmodule

// File: tb/tb_multi_divider.sv
// tb_multi_divider
//   Directed-vector bench for multi_divider (3 channels, 4-bit counters,
//   reset divisor 8). Inputs change 1 time unit after a rising edge and
//   outputs are checked at the same point.
module tb_multi_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 4;
  localparam int SEL_W  = 2;
  localparam int DEF_DV = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  multi_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  multi_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DV),
    .SEL_W       (SEL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_div(input int sel, input int data);
    bus.div_wr   = 1'b1;
    bus.div_sel  = SEL_W'(sel);
    bus.div_data = CNT_W'(data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] t2_resume;
    vectors     = 0;
    miscompares = 0;
    t2_resume   = 5'b10001;

    reset        = 1'b1;
    bus.en       = '0;
    bus.mode     = '0;
    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_data = '0;
    bus.sync_clr = 1'b0;
    repeat (2) step();
    chk_vec("rst_out", 32'(bus.out), 32'd0);
    reset = 1'b0;

    // 1: pulse mode, ch0 div=5
    write_div(0, 5);
    bus.en[0] = 1'b1;
    step();
    bus.div_wr = 1'b0;
    chk_vec("t1_wr_edge", 32'(bus.out), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk_vec("t1_pulse", 32'(bus.out[0]), 32'((k % 5) == 0));
    end
    bus.en[0] = 1'b0;

    // 2: square mode, ch1 div=3, with an enable gap
    write_div(1, 3);
    step();
    bus.div_wr  = 1'b0;
    bus.mode[1] = 1'b1;
    bus.en[1]   = 1'b1;
    step();
    chk_vec("t2_mode_chg", 32'(bus.out[1]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_vec("t2_square", 32'(bus.out[1]), 32'((k / 3) % 2));
    end
    bus.en[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_vec("t2_frozen", 32'(bus.out[1]), 32'd1);
    end
    bus.en[1] = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      step();
      chk_vec("t2_resume", 32'(bus.out[1]), 32'(t2_resume[r-1]));
    end
    bus.en[1] = 1'b0;

    // 3: clamp of div 0 on ch2, then an out-of-range write
    write_div(2, 0);
    bus.en[2] = 1'b1;
    step();
    bus.div_wr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) write_div(3, 5);
      step();
      bus.div_wr = 1'b0;
      chk_vec("t3_clamp", 32'(bus.out[2]), 32'((k % 2) == 0));
      chk_vec("t3_ch1_hold", 32'(bus.out[1]), 32'd1);
    end
    bus.en[2] = 1'b0;

    // 4: write collides with terminal event on ch0
    write_div(0, 5);
    bus.en[0] = 1'b1;
    step();
    bus.div_wr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_vec("t4_count", 32'(bus.out[0]), 32'd0);
    end
    write_div(0, 3);
    step();
    bus.div_wr = 1'b0;
    chk_vec("t4_collide", 32'(bus.out[0]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_vec("t4_new_div", 32'(bus.out[0]), 32'(k == 3));
    end

    // 5: sync_clr aligns ch0 (div 4) and ch1 (div 6)
    bus.mode[1] = 1'b0;
    bus.en[1]   = 1'b1;
    write_div(0, 4);
    step();
    write_div(1, 6);
    step();
    bus.div_wr = 1'b0;
    repeat (7) step();
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    chk_vec("t5_clr", 32'(bus.out[1:0]), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_vec("t5_ch0", 32'(bus.out[0]), 32'((k % 4) == 0));
      chk_vec("t5_ch1", 32'(bus.out[1]), 32'((k % 6) == 0));
    end

    // 6: asynchronous reset mid-cycle while both outputs are high
    #2;
    reset = 1'b1;
    #1;
    chk_vec("t6_async", 32'(bus.out), 32'd0);
    bus.en   = '1;
    bus.mode = '0;
    repeat (2) step();
    chk_vec("t6_hold", 32'(bus.out), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_vec("t6_default", 32'(bus.out), (k == 8) ? 32'd7 : 32'd0);
    end

    // maximum divisor 2**CNT_W-1 on ch2
    write_div(2, 15);
    step();
    bus.div_wr = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk_vec("max_div", 32'(bus.out[2]), 32'((k % 15) == 0));
    end

    // square mode with div=2 on ch1: period 4
    bus.mode[1] = 1'b1;
    step();
    write_div(1, 2);
    step();
    bus.div_wr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_vec("sq_div2", 32'(bus.out[1]), 32'((k / 2) % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
